// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative multiply/divide unit that owns the MIPS HI/LO registers.
// MULT/MULTU run a shift-add multiplier. DIV/DIVU run a restoring
// shift-subtract divider. Each operation takes DATA_W iteration steps plus
// one sign-fix step. MTHI/MTLO write HI/LO directly while the unit is idle.
//
// Ports
//   clk      : system clock, all state changes on the rising edge
//   rst_n    : synchronous active-low reset; aborts any operation in flight
//   start    : launch the operation selected by op (accepted only when idle)
//   op       : 00=MULT, 01=MULTU, 10=DIV, 11=DIVU
//   rs_data  : operand A / dividend / MTHI-MTLO source
//   rt_data  : operand B / divisor
//   mthi     : write rs_data into HI (idle, no start)
//   mtlo     : write rs_data into LO (idle, no start)
//   busy     : operation in progress
//   done     : one-cycle pulse, HI/LO hold the result of the finished operation
//   hi       : HI register (product high half / remainder)
//   lo       : LO register (product low half / quotient)
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              mthi,
    input  logic              mtlo,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    // ---------------------------------------------------------------- state
    state_e              state_q,   state_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic [DATA_W-1:0]   hi_q,      hi_d;
    logic [DATA_W-1:0]   lo_q,      lo_d;
    logic                div_op_q,  div_op_d;   // latched op[1]
    logic                neg_res_q, neg_res_d;  // negate product / quotient
    logic                neg_rem_q, neg_rem_d;  // negate remainder
    logic [DATA_W-1:0]   opb_q,     opb_d;      // multiplicand or divisor magnitude
    logic [2*DATA_W-1:0] acc_q,     acc_d;      // {upper, lower} working register
    logic [DATA_W-1:0]   cnt_q,     cnt_d;      // remaining iteration steps

    // ------------------------------------------------------- operand prep
    logic              op_signed;
    logic              div_zero;
    logic              rs_neg;
    logic              rt_neg;
    logic [DATA_W-1:0] rs_mag;
    logic [DATA_W-1:0] rt_mag;

    assign op_signed = ~op[0];
    assign div_zero  = op[1] && (rt_data == '0);
    assign rs_neg    = op_signed && rs_data[DATA_W-1];
    assign rt_neg    = op_signed && rt_data[DATA_W-1];

    // A divide by zero runs the divider on the raw dividend with a zero
    // divisor: every trial subtraction succeeds, so the quotient comes out
    // all ones and the remainder is the dividend itself, with no sign fix.
    // The magnitude of the most negative value wraps to itself, which is
    // exactly its unsigned magnitude, so no special case is needed there.
    assign rs_mag = (rs_neg && !div_zero) ? -rs_data : rs_data;
    assign rt_mag = rt_neg ? -rt_data : rt_data;

    // ------------------------------------------------------ iteration step
    logic [DATA_W:0]       mul_sum;   // one extra bit keeps the add carry
    logic [DATA_W:0]       div_cand;  // partial remainder shifted left plus next bit
    logic [DATA_W:0]       div_diff;
    logic [2*DATA_W-1:0]   mul_next;
    logic [2*DATA_W-1:0]   div_next;
    logic                  last_step;

    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opb_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[DATA_W-1:1]}
                               : {1'b0, acc_q[2*DATA_W-1:1]};

    assign div_cand = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign div_diff = div_cand - {1'b0, opb_q};
    // A clear borrow bit means the divisor fit: keep the difference, quotient bit 1.
    assign div_next = div_diff[DATA_W]
                    ? {div_cand[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                    : {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};

    assign last_step = (cnt_q == DATA_W'(1));

    // ------------------------------------------------------- sign fix-up
    logic [2*DATA_W-1:0] prod_fixed;
    logic [DATA_W-1:0]   quo_fixed;
    logic [DATA_W-1:0]   rem_fixed;

    assign prod_fixed = neg_res_q ? -acc_q : acc_q;
    assign quo_fixed  = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign rem_fixed  = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W]
                                  : acc_q[2*DATA_W-1:DATA_W];

    // ------------------------------------------------------ next state
    always_comb begin
        // NOTE: every *_d gets a hold value first so no path through the case
        // leaves a variable unassigned, which would infer a latch.
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div_op_d  = div_op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d    = 1'b1;
                    div_op_d  = op[1];
                    opb_d     = rt_mag;
                    acc_d     = {{DATA_W{1'b0}}, rs_mag};
                    cnt_d     = DATA_W'(DATA_W);
                    neg_res_d = !div_zero && (rs_neg ^ rt_neg);
                    neg_rem_d = op[1] && !div_zero && rs_neg;
                    state_d   = op[1] ? S_DIV : S_MUL;
                end else begin
                    // Register moves are honoured only when no operation launches.
                    if (mthi) hi_d = rs_data;
                    if (mtlo) lo_d = rs_data;
                end
            end

            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q - DATA_W'(1);
                if (last_step) state_d = S_FIX;
            end

            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q - DATA_W'(1);
                if (last_step) state_d = S_FIX;
            end

            S_FIX: begin
                if (div_op_q) begin
                    hi_d = rem_fixed;
                    lo_d = quo_fixed;
                end else begin
                    hi_d = prod_fixed[2*DATA_W-1:DATA_W];
                    lo_d = prod_fixed[DATA_W-1:0];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // computed before this edge, independent of statement order.
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            div_op_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opb_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            div_op_q  <= div_op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// sequences for the multi-cycle corner cases, and random operations compared
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

    localparam int DATA_W  = 32;
    localparam int LAT     = DATA_W + 1;
    localparam int TIMEOUT = 100;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              mthi;
    logic              mtlo;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit #(.DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model straight from the MIPS arithmetic rules.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mh, output logic [31:0] ml);
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        mh = '0;
        ml = '0;
        case (o)
            2'b00: begin
                p  = sa * sb;
                mh = p[63:32];
                ml = p[31:0];
            end
            2'b01: begin
                up = {32'h0, a} * {32'h0, b};
                mh = up[63:32];
                ml = up[31:0];
            end
            2'b10: begin
                if (b == 0) begin
                    mh = a;
                    ml = '1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    mh = 32'h0;
                    ml = 32'h8000_0000;
                end else begin
                    p  = sa / sb;
                    ml = p[31:0];
                    p  = sa % sb;
                    mh = p[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    mh = a;
                    ml = '1;
                end else begin
                    mh = a % b;
                    ml = a / b;
                end
            end
        endcase
    endfunction

    // Launches one operation from the current negedge and returns at the
    // negedge where done is seen. Operand inputs are scrambled after the start
    // edge. If inject_at > 0, a DIVU start plus mthi/mtlo is pulsed at that
    // sample to confirm they are ignored while busy.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int inject_at,
                          output logic [31:0] r_hi, output logic [31:0] r_lo);
        logic [31:0] hi0;
        logic [31:0] lo0;
        bit          held;
        int          busy_cnt;
        int          edges;
        hi0      = hi;
        lo0      = lo;
        held     = 1'b1;
        busy_cnt = 0;
        edges    = -1;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        start    = 1'b1;
        for (int n = 1; n <= TIMEOUT; n++) begin
            @(negedge clk);
            start   = 1'b0;
            mthi    = 1'b0;
            mtlo    = 1'b0;
            rs_data = $urandom;
            rt_data = $urandom;
            if (busy) busy_cnt++;
            if (done) begin
                edges = n - 1;
                break;
            end
            if (hi !== hi0 || lo !== lo0) held = 1'b0;
            if (n == inject_at) begin
                start   = 1'b1;
                op      = 2'b11;
                rs_data = 32'd9;
                rt_data = 32'd3;
                mthi    = 1'b1;
                mtlo    = 1'b1;
            end
        end
        check({name, "_latency"}, 64'(edges), 64'(LAT));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(LAT));
        check({name, "_busy_low_at_done"}, 64'(busy), 64'd0);
        check({name, "_hilo_held"}, 64'(held), 64'd1);
        r_hi = hi;
        r_lo = lo;
    endtask

    // One cycle after done: pulse must have dropped and results must hold.
    task automatic check_after_done(input string name);
        logic [31:0] h;
        logic [31:0] l;
        h = hi;
        l = lo;
        @(negedge clk);
        check({name, "_done_single_pulse"}, 64'(done), 64'd0);
        check({name, "_idle_busy"}, 64'(busy), 64'd0);
        check({name, "_hold"}, {hi, lo}, {h, l});
    endtask

    // ---------------------------------------------------------------- test
    initial begin
        logic [31:0] r_hi;
        logic [31:0] r_lo;
        logic [31:0] m_hi;
        logic [31:0] m_lo;
        bit          saw_done;

        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        rs_data = '0;
        rt_data = '0;
        mthi    = 1'b0;
        mtlo    = 1'b0;

        vecs.push_back('{2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5"});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_minxmin"});
        vecs.push_back('{2'b00, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, "mult_7xm1"});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2"});
        vecs.push_back('{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7dm2"});
        vecs.push_back('{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        "divu_100d7"});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_overflow"});
        vecs.push_back('{2'b11, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, "divu_by_zero"});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by_zero"});

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_hi",   64'(hi),   64'd0);
        check("reset_lo",   64'(lo),   64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // MTHI / MTLO, individually and together; done must never pulse.
        saw_done = 1'b0;
        rs_data  = 32'h1234_5678;
        mthi     = 1'b1;
        @(negedge clk);
        saw_done |= done;
        mthi     = 1'b0;
        rs_data  = 32'h9ABC_DEF0;
        mtlo     = 1'b1;
        @(negedge clk);
        saw_done |= done;
        mtlo     = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        check("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
        rs_data = 32'h0BAD_F00D;
        mthi    = 1'b1;
        mtlo    = 1'b1;
        @(negedge clk);
        saw_done |= done;
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthi_mtlo_both", {hi, lo}, {32'h0BAD_F00D, 32'h0BAD_F00D});
        @(negedge clk);
        saw_done |= done;
        check("mthi_mtlo_no_done", 64'(saw_done), 64'd0);

        // Directed vector table.
        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 0, r_hi, r_lo);
            check({vecs[i].name, "_hi"}, 64'(r_hi), 64'(vecs[i].exp_hi));
            check({vecs[i].name, "_lo"}, 64'(r_lo), 64'(vecs[i].exp_lo));
            check_after_done(vecs[i].name);
        end

        // start + mthi on the same edge: start wins, HI/LO untouched until done.
        mthi = 1'b1;
        mtlo = 1'b1;
        run_op("start_beats_mthi", 2'b01, 32'd6, 32'd7, 0, r_hi, r_lo);
        check("start_beats_mthi_result", {r_hi, r_lo}, {32'd0, 32'd42});

        // Start/MTHI/MTLO pulsed mid-operation must be ignored.
        @(negedge clk);
        run_op("busy_ignore", 2'b01, 32'd3, 32'd4, 10, r_hi, r_lo);
        check("busy_ignore_result", {r_hi, r_lo}, {32'd0, 32'd12});
        check_after_done("busy_ignore");

        // Back-to-back: second start issued in the done cycle.
        run_op("b2b_first", 2'b11, 32'd1000, 32'd33, 0, r_hi, r_lo);
        check("b2b_first_result", {r_hi, r_lo}, {32'd10, 32'd30});
        run_op("b2b_second", 2'b00, 32'hFFFF_FF00, 32'd16, 0, r_hi, r_lo);
        check("b2b_second_result", {r_hi, r_lo}, {32'hFFFF_FFFF, 32'hFFFF_F000});
        check_after_done("b2b_second");

        // Reset in the middle of a DIV aborts it: no done, HI/LO cleared.
        rs_data = 32'hCAFE_0001;
        mthi    = 1'b1;
        mtlo    = 1'b1;
        @(negedge clk);
        mthi    = 1'b0;
        mtlo    = 1'b0;
        op      = 2'b10;
        rs_data = 32'd5000;
        rt_data = 32'd7;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("abort_busy_before_reset", 64'(busy), 64'd1);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy",  64'(busy), 64'd0);
        check("abort_done",  64'(done), 64'd0);
        check("abort_hilo",  {hi, lo}, 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw_done |= done;
        end
        check("abort_no_late_done", 64'(saw_done), 64'd0);
        check("abort_hilo_stays_zero", {hi, lo}, 64'd0);

        // Random operations against the reference model.
        for (int k = 0; k < 40; k++) begin
            logic [1:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = '0;
            if ($urandom_range(0, 7) == 0) rb = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            model(ro, ra, rb, m_hi, m_lo);
            run_op($sformatf("rand%0d", k), ro, ra, rb, 0, r_hi, r_lo);
            check($sformatf("rand%0d_op%0d_%h_%h", k, ro, ra, rb), {r_hi, r_lo}, {m_hi, m_lo});
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
